// File: rtl/fsm_table_engine.sv
// fsm_table_engine
//   Table-driven Moore state machine. A next-state table indexed by
//   {current state, condition inputs} and an output table indexed by state
//   are both written through a small configuration port and read
//   combinationally. The engine adds a dwell-timeout that returns a stuck
//   (self-looping) state to the reset state, recovery from illegal state
//   codes, and validation of configuration writes.
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   en         in   1   advance enable (0 = hold)
//   x          in   NI  condition inputs
//   tmo_limit  in   TW  dwell limit in cycles, 0 disables the timeout
//   cfg_we     in   1   table write strobe
//   cfg_sel    in   1   0 = next-state table, 1 = output table
//   cfg_addr   in   AW  next-state: {state, x}; output: state in low SW bits
//   cfg_data   in   CW  value written (low SW or OW bits used)
//   y          out  SW  current state (registered)
//   z          out  OW  Moore output for y (registered)
//   chg        out  1   pulse: y changed on this edge
//   tmo        out  1   pulse: timeout forced y to RST_ST
//   cfg_err    out  1   pulse: last configuration write rejected
module fsm_table_engine #(
  parameter  int SW     = 3,
  parameter  int NS     = 7,
  parameter  int NI     = 3,
  parameter  int OW     = 3,
  parameter  int TW     = 8,
  parameter  int RST_ST = 0,
  localparam int AW     = SW + NI,
  localparam int CW     = (SW > OW) ? SW : OW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [NI-1:0] x,
  input  logic [TW-1:0] tmo_limit,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic [SW-1:0] y,
  output logic [OW-1:0] z,
  output logic          chg,
  output logic          tmo,
  output logic          cfg_err
);

  localparam int NT_DEPTH = 1 << AW;
  localparam int OT_DEPTH = 1 << SW;

  // NS may equal 2^SW, so the legal-state bound carries one extra bit.
  localparam logic [SW:0]   NS_V      = NS[SW:0];
  localparam logic [SW-1:0] RST_V     = RST_ST[SW-1:0];
  localparam logic [TW-1:0] DWELL_ONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] DWELL_MAX = {TW{1'b1}};

  // True when a state code lies inside the legal range 0..NS-1.
  function automatic logic state_legal(input logic [SW-1:0] s);
    return ({1'b0, s} < NS_V);
  endfunction

  // Table storage
  logic [SW-1:0] nt_mem_r [NT_DEPTH];
  logic [OW-1:0] ot_mem_r [OT_DEPTH];

  // Architectural state
  logic [SW-1:0] y_r;
  logic [OW-1:0] z_r;
  logic          chg_r;
  logic          tmo_r;
  logic          cfg_err_r;
  logic [TW-1:0] dwell_r;

  // Combinational step and configuration decode
  logic [AW-1:0] lut_idx_s;
  logic [SW-1:0] nt_val_s;
  logic          y_legal_s;
  logic          tmo_hit_s;
  logic [SW-1:0] y_next_s;
  logic [OW-1:0] z_next_s;
  logic [SW-1:0] cfg_nt_state_s;
  logic [NI-1:0] cfg_ot_high_s;
  logic [SW-1:0] cfg_ot_state_s;
  logic          cfg_ok_s;

  assign lut_idx_s      = {y_r, x};
  assign nt_val_s       = nt_mem_r[lut_idx_s];
  assign y_legal_s      = state_legal(y_r);
  assign cfg_nt_state_s = cfg_addr[AW-1:NI];
  assign cfg_ot_high_s  = cfg_addr[AW-1:SW];
  assign cfg_ot_state_s = cfg_addr[SW-1:0];

  // Next-state selection: illegal-state recovery, then timeout, then table.
  always_comb begin
    tmo_hit_s = 1'b0;
    y_next_s  = y_r;
    if (!y_legal_s) begin
      y_next_s = RST_V;
    end else if ((tmo_limit != {TW{1'b0}}) && (y_r != RST_V) &&
                 (dwell_r == (tmo_limit - DWELL_ONE)) && (nt_val_s == y_r)) begin
      // Stuck in a self-loop for tmo_limit cycles: bail out to reset state.
      tmo_hit_s = 1'b1;
      y_next_s  = RST_V;
    end else begin
      y_next_s = nt_val_s;
    end
  end

  // Output follows the state being entered, using pre-edge table contents.
  assign z_next_s = ot_mem_r[y_next_s];

  // Configuration write validation.
  always_comb begin
    cfg_ok_s = 1'b0;
    if (cfg_sel == 1'b0) begin
      cfg_ok_s = state_legal(cfg_data[SW-1:0]) && state_legal(cfg_nt_state_s);
    end else begin
      cfg_ok_s = (cfg_ot_high_s == {NI{1'b0}}) && state_legal(cfg_ot_state_s);
    end
  end

  // Table storage: cleared by reset, otherwise written by accepted cfg writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NT_DEPTH; i++) begin
        nt_mem_r[i] <= RST_V;
      end
      for (int j = 0; j < OT_DEPTH; j++) begin
        ot_mem_r[j] <= {OW{1'b0}};
      end
    end else if (cfg_we && cfg_ok_s) begin
      if (cfg_sel == 1'b0) begin
        nt_mem_r[cfg_addr] <= cfg_data[SW-1:0];
      end else begin
        ot_mem_r[cfg_ot_state_s] <= cfg_data[OW-1:0];
      end
    end
  end

  // State, output, pulse flags and dwell counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r       <= RST_V;
      z_r       <= {OW{1'b0}};
      chg_r     <= 1'b0;
      tmo_r     <= 1'b0;
      cfg_err_r <= 1'b0;
      dwell_r   <= {TW{1'b0}};
    end else begin
      cfg_err_r <= cfg_we && !cfg_ok_s;
      if (en) begin
        y_r   <= y_next_s;
        z_r   <= z_next_s;
        chg_r <= (y_next_s != y_r);
        tmo_r <= tmo_hit_s;
        if (y_next_s != y_r) begin
          dwell_r <= {TW{1'b0}};
        end else if (dwell_r != DWELL_MAX) begin
          dwell_r <= dwell_r + DWELL_ONE;
        end
      end else begin
        chg_r <= 1'b0;
        tmo_r <= 1'b0;
      end
    end
  end

  assign y       = y_r;
  assign z       = z_r;
  assign chg     = chg_r;
  assign tmo     = tmo_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_fsm_table_engine.sv
// tb_fsm_table_engine
//   Directed testbench for fsm_table_engine with default parameters
//   (SW=3, NS=7, NI=3, OW=3, TW=8, RST_ST=0). Expected values are
//   hand-computed from the table contents programmed by the bench.
module tb_fsm_table_engine;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] x;
  logic [7:0] tmo_limit;
  logic       cfg_we;
  logic       cfg_sel;
  logic [5:0] cfg_addr;
  logic [2:0] cfg_data;
  logic [2:0] y;
  logic [2:0] z;
  logic       chg;
  logic       tmo;
  logic       cfg_err;

  int errors;
  int checks;

  fsm_table_engine dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .x         (x),
    .tmo_limit (tmo_limit),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .y         (y),
    .z         (z),
    .chg       (chg),
    .tmo       (tmo),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] ey, input logic [2:0] ez,
                        input logic echg, input logic etmo);
    chk({tag, ".y"},   32'(y),   32'(ey));
    chk({tag, ".z"},   32'(z),   32'(ez));
    chk({tag, ".chg"}, 32'(chg), 32'(echg));
    chk({tag, ".tmo"}, 32'(tmo), 32'(etmo));
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [5:0] addr, input logic [2:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = addr;
    cfg_data = data;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    en        = 1'b0;
    x         = 3'd0;
    tmo_limit = 8'd0;
    cfg_we    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_addr  = 6'd0;
    cfg_data  = 3'd0;

    // Reset state
    step();
    step();
    chk_st("reset", 3'd0, 3'd0, 1'b0, 1'b0);
    chk("reset.cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;

    // Cleared tables: the machine never leaves state 0
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x = 3'($urandom_range(7, 0));
      step();
      chk_st("idle", 3'd0, 3'd0, 1'b0, 1'b0);
    end
    en = 1'b0;

    // Program chain 0->1 on x[0], 1->2 on x[1], 2->0, OT[2]=100
    wr(1'b0, 6'o01, 3'd1);
    wr(1'b0, 6'o03, 3'd1);
    wr(1'b0, 6'o05, 3'd1);
    wr(1'b0, 6'o07, 3'd1);
    wr(1'b0, 6'o12, 3'd2);
    wr(1'b0, 6'o13, 3'd2);
    wr(1'b0, 6'o16, 3'd2);
    wr(1'b0, 6'o17, 3'd2);
    wr(1'b1, 6'o02, 3'b100);
    chk("prog.cfg_err", 32'(cfg_err), 32'd0);
    chk_st("prog_hold", 3'd0, 3'd0, 1'b0, 1'b0);

    en = 1'b1;
    x  = 3'b011;
    step(); chk_st("chain1", 3'd1, 3'd0,   1'b1, 1'b0);
    step(); chk_st("chain2", 3'd2, 3'b100, 1'b1, 1'b0);
    step(); chk_st("chain3", 3'd0, 3'd0,   1'b1, 1'b0);
    step(); chk_st("chain4", 3'd1, 3'd0,   1'b1, 1'b0);
    en = 1'b0;
    step(); chk_st("hold", 3'd1, 3'd0, 1'b0, 1'b0);

    // Timeout: state 1 self-loops on x=000, limit 4
    wr(1'b0, 6'o10, 3'd1);
    en        = 1'b1;
    x         = 3'b000;
    tmo_limit = 8'd4;
    step(); chk_st("dwell1", 3'd1, 3'd0, 1'b0, 1'b0);
    step(); chk_st("dwell2", 3'd1, 3'd0, 1'b0, 1'b0);
    step(); chk_st("dwell3", 3'd1, 3'd0, 1'b0, 1'b0);
    step(); chk_st("timeout", 3'd0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(); chk_st("rst_st_no_tmo", 3'd0, 3'd0, 1'b0, 1'b0);
    end

    // Timeout disabled: state 1 persists
    tmo_limit = 8'd0;
    x = 3'b001;
    step(); chk_st("enter1", 3'd1, 3'd0, 1'b1, 1'b0);
    x = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step(); chk_st("no_tmo", 3'd1, 3'd0, 1'b0, 1'b0);
    end
    en = 1'b0;

    // Rejected next-state data (7 >= NS), entry stays 1
    wr(1'b0, 6'o10, 3'd7);
    chk("rej_data.cfg_err", 32'(cfg_err), 32'd1);
    step();
    chk("err_pulse.cfg_err", 32'(cfg_err), 32'd0);
    en = 1'b1;
    step(); chk_st("entry_kept", 3'd1, 3'd0, 1'b0, 1'b0);
    en = 1'b0;
    wr(1'b0, 6'o10, 3'd5);
    chk("acc_data.cfg_err", 32'(cfg_err), 32'd0);
    en = 1'b1;
    step(); chk_st("entry_new", 3'd5, 3'd0, 1'b1, 1'b0);
    step(); chk_st("back_to_0", 3'd0, 3'd0, 1'b1, 1'b0);
    en = 1'b0;

    // Other rejection boundaries
    wr(1'b0, 6'o70, 3'd1);
    chk("rej_nt_addr.cfg_err", 32'(cfg_err), 32'd1);
    wr(1'b1, 6'o07, 3'd1);
    chk("rej_ot_state.cfg_err", 32'(cfg_err), 32'd1);
    wr(1'b1, 6'o12, 3'd1);
    chk("rej_ot_high.cfg_err", 32'(cfg_err), 32'd1);
    wr(1'b1, 6'o06, 3'b010);
    chk("acc_ot6.cfg_err", 32'(cfg_err), 32'd0);

    // Same-edge write and step: old entry used, new entry next time
    en       = 1'b1;
    x        = 3'b001;
    cfg_we   = 1'b1;
    cfg_sel  = 1'b0;
    cfg_addr = 6'o01;
    cfg_data = 3'd3;
    step();
    cfg_we   = 1'b0;
    chk_st("same_edge_old", 3'd1, 3'd0, 1'b1, 1'b0);
    chk("same_edge.cfg_err", 32'(cfg_err), 32'd0);
    step(); chk_st("same_edge_ret", 3'd0, 3'd0, 1'b1, 1'b0);
    step(); chk_st("same_edge_new", 3'd3, 3'd0, 1'b1, 1'b0);

    // Walk to state 2, then reset mid-run with en and cfg_we active
    x = 3'b011;
    step(); chk_st("walk0", 3'd0, 3'd0,   1'b1, 1'b0);
    step(); chk_st("walk1", 3'd1, 3'd0,   1'b1, 1'b0);
    step(); chk_st("walk2", 3'd2, 3'b100, 1'b1, 1'b0);
    reset    = 1'b1;
    cfg_we   = 1'b1;
    cfg_sel  = 1'b1;
    cfg_addr = 6'o00;
    cfg_data = 3'd5;
    step();
    reset  = 1'b0;
    cfg_we = 1'b0;
    chk_st("mid_reset", 3'd0, 3'd0, 1'b0, 1'b0);
    chk("mid_reset.cfg_err", 32'(cfg_err), 32'd0);
    step(); chk_st("tables_cleared", 3'd0, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
